vga_layer_mixer: RTL

Parametrised, pipelined pixel compositor for the TypeRacer VGA path. It takes per-layer colour indices from every text, number and dictionary display instance and reduces them to one winning index per pixel, in either max-index or ordered-priority mode. The winning index is mapped through a runtime-writable palette to 12-bit RGB. Palette updates are frame-synchronised through shadow registers, and selected layers can blink. It sits between the display instances and the `{vgaRed, vgaGreen, vgaBlue}` outputs. It replaces the fixed two-level max tree and hard-coded colour case.

---
 rtl/vga_layer_mixer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/vga_layer_mixer.sv
// -----------------------------------------------------------------------------
// vga_layer_mixer
//
// Three-stage pixel compositor. Per-layer colour indices are blink-masked,
// reduced to one winning index (max-index or lowest-layer-priority), then
// looked up in a frame-synchronised, runtime-writable palette.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   pix_en       pixel strobe; pipeline advances only when 1
//   valid        visible-area flag, travels with the pixel
//   frame_start  one-cycle pulse at start of vertical blank
//   layer_id     LAYERS packed indices, layer k at [k*IDW +: IDW]
//   blink_mask   per-layer blink enable
//   mode         0 = max index wins, 1 = lowest non-zero layer wins
//   pal_we       shadow palette write strobe
//   pal_addr     shadow palette entry
//   pal_data     12-bit RGB for the shadow entry
//   rgb          {R,G,B} output, 4 bits each
//   rgb_valid    valid aligned with rgb
// -----------------------------------------------------------------------------
module vga_layer_mixer #(
    parameter int LAYERS       = 13,
    parameter int IDW          = 3,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_en,
    input  logic                  valid,
    input  logic                  frame_start,
    input  logic [LAYERS*IDW-1:0] layer_id,
    input  logic [LAYERS-1:0]     blink_mask,
    input  logic                  mode,
    input  logic                  pal_we,
    input  logic [IDW-1:0]        pal_addr,
    input  logic [11:0]           pal_data,
    output logic [11:0]           rgb,
    output logic                  rgb_valid
);

    localparam int DEPTH = 1 << IDW;
    localparam int FCW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_FRAMES - 1);

    // Power-on colour table shared by both palette banks.
    function automatic logic [11:0] pal_default(input int idx);
        case (idx)
            0:       return 12'hFFF;
            1:       return 12'h0FF;
            2:       return 12'hF00;
            3:       return 12'h0F0;
            4:       return 12'h000;
            default: return 12'h00F;
        endcase
    endfunction

    // Palette banks
    logic [11:0] shadow_q [DEPTH];
    logic [11:0] shadow_d [DEPTH];
    logic [11:0] active_q [DEPTH];

    // Blink state
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           blink_phase_q, blink_phase_d;

    // Pipeline stages
    logic [LAYERS*IDW-1:0] s1_id_q, s1_id_d;
    logic                  s1_valid_q;
    logic [IDW-1:0]        s2_win_q, s2_win_d;
    logic                  s2_valid_q;
    logic [11:0]           rgb_q, rgb_d;
    logic                  rgb_valid_q;

    // Shadow bank next state. The commit on frame_start copies shadow_d, so a
    // write landing in the same cycle is already part of the committed copy.
    always_comb begin
        // NOTE: every always_comb target gets a default first; a path that
        // leaves it unassigned would infer a latch.
        shadow_d = shadow_q;
        if (pal_we) begin
            shadow_d[pal_addr] = pal_data;
        end
    end

    // Frame counter and blink phase.
    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_start) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Stage 1: blanked layers become transparent during the off phase.
    always_comb begin
        s1_id_d = layer_id;
        for (int k = 0; k < LAYERS; k++) begin
            if (blink_mask[k] && blink_phase_q) begin
                s1_id_d[k*IDW +: IDW] = '0;
            end
        end
    end

    // Stage 2: reduction. Mode 1 scans from the top layer down so the
    // lowest-numbered non-zero layer is the last to overwrite the winner.
    always_comb begin
        s2_win_d = '0;
        if (mode) begin
            for (int k = LAYERS - 1; k >= 0; k--) begin
                if (s1_id_q[k*IDW +: IDW] != '0) begin
                    s2_win_d = s1_id_q[k*IDW +: IDW];
                end
            end
        end else begin
            for (int k = 0; k < LAYERS; k++) begin
                if (s1_id_q[k*IDW +: IDW] > s2_win_d) begin
                    s2_win_d = s1_id_q[k*IDW +: IDW];
                end
            end
        end
    end

    // Stage 3: palette lookup, blanked outside the visible area.
    always_comb begin
        rgb_d = s2_valid_q ? active_q[s2_win_q] : 12'h000;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the palette banks are reset explicitly because their
            // power-on contents are a defined colour table, not don't-cares.
            for (int i = 0; i < DEPTH; i++) begin
                shadow_q[i] <= pal_default(i);
                active_q[i] <= pal_default(i);
            end
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            s1_id_q       <= '0;
            s1_valid_q    <= 1'b0;
            s2_win_q      <= '0;
            s2_valid_q    <= 1'b0;
            rgb_q         <= 12'h000;
            rgb_valid_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow_q[i] <= shadow_d[i];
                if (frame_start) begin
                    active_q[i] <= shadow_d[i];
                end
            end
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            if (pix_en) begin
                s1_id_q     <= s1_id_d;
                s1_valid_q  <= valid;
                s2_win_q    <= s2_win_d;
                s2_valid_q  <= s1_valid_q;
                rgb_q       <= rgb_d;
                rgb_valid_q <= s2_valid_q;
            end
        end
    end

    assign rgb       = rgb_q;
    assign rgb_valid = rgb_valid_q;

endmodule
